// File: rtl/servo_xy_pkg.sv
// Shared types and constants for the servo XY slew scheduler.
package servo_xy_pkg;

  localparam int unsigned POS_W_DEFAULT  = 8;
  localparam int unsigned CENTER_DEFAULT = 128;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SLEW_X,
    SLEW_Y,
    PUBLISH
  } state_e;

  typedef logic [POS_W_DEFAULT-1:0] pos_t;

endpackage

// File: rtl/servo_slew_step.sv
// Combinational slew step: moves cur toward tgt by at most STEP counts.
// STEP = 0 means jump straight to the target.
module servo_slew_step #(
  parameter int unsigned POS_W = 8,
  parameter int unsigned STEP  = 4
) (
  input  logic [POS_W-1:0] cur,
  input  logic [POS_W-1:0] tgt,
  output logic [POS_W-1:0] next
);

  localparam logic [POS_W:0]   STEP_MAG = (POS_W+1)'(STEP);
  localparam logic [POS_W-1:0] STEP_INC = POS_W'(STEP);

  // One extra bit so the difference never wraps.
  logic signed [POS_W:0] diff;
  logic        [POS_W:0] mag;

  // Difference, magnitude and the limited next position.
  always_comb begin
    diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
    mag  = diff[POS_W] ? unsigned'(-diff) : unsigned'(diff);
    if (STEP == 0 || mag <= STEP_MAG) begin
      next = tgt;
    end else if (!diff[POS_W]) begin
      // |diff| > STEP here, so cur + STEP < tgt and cannot overflow.
      next = cur + STEP_INC;
    end else begin
      next = cur - STEP_INC;
    end
  end

endmodule

// File: rtl/servo_xy_slew_scheduler.sv
// Servo XY slew scheduler. Accepts per-axis target commands, and on each frame
// tick slews X then Y through one shared step unit, then publishes both
// positions together with a one-cycle update strobe.
// Optional build macro SERVO_SOFT_LIMIT_EN clamps accepted targets to
// [MIN_POS, MAX_POS].
module servo_xy_slew_scheduler
  import servo_xy_pkg::*;
#(
  parameter int unsigned POS_W   = POS_W_DEFAULT,
  parameter int unsigned STEP    = 4,
  parameter int unsigned CENTER  = CENTER_DEFAULT,
  parameter int unsigned MIN_POS = 16,
  parameter int unsigned MAX_POS = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_axis,
  input  logic [POS_W-1:0] cmd_pos,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             update_stb,
  output logic             busy,
  output logic             at_target,
  output logic             overrun
);

  localparam logic [POS_W-1:0] CENTER_P = POS_W'(CENTER);

  state_e           state;
  logic [POS_W-1:0] cur_x, cur_y;
  logic [POS_W-1:0] tgt_x, tgt_y;
  logic [POS_W-1:0] cmd_pos_eff;
  logic [POS_W-1:0] op_cur, op_tgt;
  logic [POS_W-1:0] step_next;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign at_target = (cur_x == tgt_x) && (cur_y == tgt_y);

`ifdef SERVO_SOFT_LIMIT_EN
  localparam logic [POS_W-1:0] MIN_P = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0] MAX_P = POS_W'(MAX_POS);

  // Clamp the incoming target into the soft-limit window.
  always_comb begin
    cmd_pos_eff = cmd_pos;
    if (cmd_pos < MIN_P) begin
      cmd_pos_eff = MIN_P;
    end else if (cmd_pos > MAX_P) begin
      cmd_pos_eff = MAX_P;
    end
  end
`else
  assign cmd_pos_eff = cmd_pos;

  // Limits have no effect in this build; referenced only for a sanity hook.
  if (MIN_POS > MAX_POS) begin : g_limits_inverted
  end
`endif

  // Operand mux for the shared step unit: Y operands only in SLEW_Y.
  always_comb begin
    op_cur = cur_x;
    op_tgt = tgt_x;
    if (state == SLEW_Y) begin
      op_cur = cur_y;
      op_tgt = tgt_y;
    end
  end

  servo_slew_step #(
    .POS_W (POS_W),
    .STEP  (STEP)
  ) u_step (
    .cur  (op_cur),
    .tgt  (op_tgt),
    .next (step_next)
  );

  // Sequencer FSM with registered positions, strobe and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_x      <= CENTER_P;
      cur_y      <= CENTER_P;
      tgt_x      <= CENTER_P;
      tgt_y      <= CENTER_P;
      pos_x      <= CENTER_P;
      pos_y      <= CENTER_P;
      update_stb <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      update_stb <= 1'b0;
      // A tick outside IDLE is dropped; remember that it happened.
      if (frame_tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          // Target written at the same edge as a tick, so that slew sees it.
          if (cmd_valid) begin
            if (cmd_axis == AXIS_Y) begin
              tgt_y <= cmd_pos_eff;
            end else begin
              tgt_x <= cmd_pos_eff;
            end
          end
          if (frame_tick) begin
            state <= SLEW_X;
          end
        end
        SLEW_X: begin
          cur_x <= step_next;
          state <= SLEW_Y;
        end
        SLEW_Y: begin
          cur_y <= step_next;
          state <= PUBLISH;
        end
        PUBLISH: begin
          pos_x      <= cur_x;
          pos_y      <= cur_y;
          update_stb <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/servo_xy_slew_scheduler.md
Name: servo_xy_slew_scheduler

Overview:
- Sequences position updates for the X and Y RC-servo PWM generators inside the servo XY top level.
- Accepts target-position commands over a valid/ready handshake.
- On each 20 ms frame tick, moves each axis's current position toward its target by at most STEP counts.
- Time-shares a single slew-step unit between the two axes, then publishes both positions to the PWM generators at the same time.

Parameters:
- POS_W, 8, width of a position value (unsigned; 0 = full left, 2^POS_W-1 = full right).
- STEP, 4, maximum change per frame per axis. STEP = 0 means jump straight to the target.
- CENTER, 128, reset value of every position and target register.
- MIN_POS, 16, lower soft limit (used only when SERVO_SOFT_LIMIT_EN is defined).
- MAX_POS, 240, upper soft limit (used only when SERVO_SOFT_LIMIT_EN is defined).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse from the 20 ms frame timer.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_axis  in  1  0 = X, 1 = Y.
- cmd_pos  in  POS_W  target position.
- pos_x  out  POS_W  published X position, feeds the PWM generator.
- pos_y  out  POS_W  published Y position, feeds the PWM generator.
- update_stb  out  1  one-cycle pulse; pos_x and pos_y have just changed.
- busy  out  1  high whenever the state is not IDLE.
- at_target  out  1  current position equals target on both axes.
- overrun  out  1  sticky flag: a frame_tick was dropped.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - cur_x, cur_y, tgt_x, tgt_y, pos_x and pos_y all take the value CENTER.
  - update_stb = 0, overrun = 0, state = IDLE.
  - After reset, cmd_ready = 1 and at_target = 1.
- FSM states: IDLE -> SLEW_X -> SLEW_Y -> PUBLISH -> IDLE. Every non-IDLE state lasts exactly one cycle.
- Command handshake:
  - cmd_ready = (state == IDLE), combinational.
  - A command is accepted when cmd_valid and cmd_ready are both high at a clock edge. The selected tgt register is written at that edge.
  - While cmd_ready is low, cmd_valid must be held high and cmd_pos and cmd_axis held stable until the command is accepted.
- Frame tick:
  - frame_tick sampled high in IDLE at edge E0 moves the FSM to SLEW_X.
  - cur_x updates at E1, cur_y updates at E2.
  - At E3, pos_x <= cur_x, pos_y <= cur_y and update_stb <= 1. update_stb drops at E4.
- Command and tick on the same edge in IDLE: the target is written at E0, so the slew uses the new target.
- frame_tick high in any state other than IDLE: the tick is ignored and overrun is set to 1. overrun clears only on reset.
- Slew-step arithmetic (shared unit; the operands are muxed by state):
  - d = tgt - cur, computed as a 9-bit signed value. No wrap-around.
  - If |d| <= STEP, or STEP == 0: next = tgt.
  - Otherwise: next = cur + STEP if d > 0, cur - STEP if d < 0.
  - The result always stays within [0, 2^POS_W-1].
- at_target = (cur_x == tgt_x) && (cur_y == tgt_y), combinational from registers. It reflects cur, not the published pos.
- Reset mid-sequence: the sequence is aborted and no update_stb is generated. Outputs return to CENTER.

Optional Feature:
- Macro: SERVO_SOFT_LIMIT_EN.
- Defined: on acceptance, cmd_pos is clamped to [MIN_POS, MAX_POS] before it is written to the tgt register.
- Undefined: cmd_pos is written unmodified, and MIN_POS and MAX_POS are ignored.

Decomposition:
- Package servo_xy_pkg holds:
  - POS_W_DEFAULT and CENTER_DEFAULT constants.
  - AXIS_X = 1'b0 and AXIS_Y = 1'b1.
  - A typedef for the FSM state enum (IDLE, SLEW_X, SLEW_Y, PUBLISH).
  - A typedef for the position type.
- Sub-module servo_slew_step: combinational, with inputs cur and tgt and output next, parameterised by POS_W and STEP. It is instantiated once and shared between the axes.

Test Plan:
- Reset release -> pos_x = pos_y = 128, update_stb = 0, cmd_ready = 1, at_target = 1, overrun = 0.
- Command X = 140, then 4 ticks spaced apart -> pos_x = 132, 136, 140, 140. Exactly one update_stb per tick, 3 cycles after the tick. at_target = 1 after the third tick.
- Command Y = 126 (difference 2 <= STEP), then 1 tick -> pos_y = 126 and pos_x is unchanged.
- Command X = 200 and frame_tick on the same IDLE cycle -> pos_x = 132 at E3. cmd_ready is low for the 3 cycles after E0.
- Tick again one cycle after a tick -> overrun = 1, only one update_stb, position advances by a single STEP.
- rst_n pulsed low while in SLEW_Y -> pos_x and pos_y show 128 immediately and no update_stb. With SERVO_SOFT_LIMIT_EN defined, a command of X = 250 followed by ticks saturates at pos_x = 240.
